quad_encoder_frontend: RTL and testbench

Conditions the raw quadrature encoder inputs and measures motor speed for the downstream PID/PWM motor drive stage. Internal stages, in order:
- synchroniser;
- per-channel glitch filter;
- quadrature decoder (position and direction);
- period counter (clocks between filtered A rising edges) with stall detection.
Outputs are registered. period_out feeds the controller's measured-period input. direction uses the same 2'b10/2'b01/2'b00 encoding the drive stage consumes.

---
 rtl/quad_encoder_frontend.sv | 241 ++++++++++++++++++++++++
 tb/tb_quad_encoder_frontend.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_frontend.sv
// -----------------------------------------------------------------------------
// quad_encoder_frontend
//
// Purpose:
//   Conditions raw quadrature encoder channels and measures motor speed for
//   the downstream PID/PWM drive stage. The processing chain is:
//     1. two-flop synchroniser per channel
//     2. per-channel glitch filter (FILTER_LEN stable cycles to change)
//     3. quadrature decoder (signed position, direction, illegal-step flag)
//     4. period counter between filtered A rising edges, with stall detection
//   All outputs are registered.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   encoder_a    in   raw encoder channel A (asynchronous)
//   encoder_b    in   raw encoder channel B (asynchronous)
//   clear_err    in   synchronous clear of illegal_err (a same-cycle set wins)
//   position     out  [POS_WIDTH-1:0] signed quadrature count, wraps
//   direction    out  [1:0] 2'b10 forward, 2'b01 reverse, 2'b00 stopped
//   period_out   out  [PERIOD_WIDTH-1:0] last A rise-to-rise period in clocks
//                     (all ones after reset or on stall)
//   period_valid out  one-cycle strobe whenever period_out is written
//   stall        out  no A rising edge within STALL_LIMIT clocks
//   illegal_err  out  sticky flag, a two-bit (skipped) transition was seen
//
// Handshake: there is no backpressure. period_valid is a pure strobe,
// high for exactly the one cycle in which period_out takes a new value;
// a consumer that is not sampling in that cycle simply misses it.
// -----------------------------------------------------------------------------
module quad_encoder_frontend #(
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned POS_WIDTH    = 16,
    parameter int unsigned STALL_LIMIT  = 32'h0000_FFFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    encoder_a,
    input  logic                    encoder_b,
    input  logic                    clear_err,
    output logic [POS_WIDTH-1:0]    position,
    output logic [1:0]              direction,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    illegal_err
);

    // Filter counter compares against FILTER_LEN-1: with the two sync
    // stages this gives a FILTER_LEN+2 clock latency from a raw change.
    localparam logic [3:0]              FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [PERIOD_WIDTH-1:0] STALL_LIM = PERIOD_WIDTH'(STALL_LIMIT);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_REV  = 2'b01;
    localparam logic [1:0] DIR_FWD  = 2'b10;

    // Period measurement state: IDLE until the first A rise (after reset
    // or after a stall), ARMED while timing rise-to-rise intervals.
    typedef enum logic {
        MEAS_IDLE  = 1'b0,
        MEAS_ARMED = 1'b1
    } meas_state_t;

    // Channel bit order throughout: [1] = A, [0] = B.
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] filt_q, filt_d;
    logic [3:0] fcnt_q [2];
    logic [3:0] fcnt_d [2];

    logic [1:0]              prev_q, prev_d;
    logic [POS_WIDTH-1:0]    pos_q, pos_d;
    logic [1:0]              dir_q, dir_d;
    logic                    err_q, err_d;

    meas_state_t             meas_q, meas_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] per_q, per_d;
    logic                    valid_q, valid_d;
    logic                    stall_q, stall_d;

    logic [1:0]              cur;
    logic                    step_fwd;
    logic                    step_rev;
    logic                    step_bad;
    logic                    a_rise;
    logic [PERIOD_WIDTH-1:0] cnt_plus1;

    // -------------------------------------------------------------------------
    // Synchroniser and glitch filter
    // -------------------------------------------------------------------------
    always_comb begin
        meta_d = {encoder_a, encoder_b};
        sync_d = meta_q;
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            // Counter runs only while the synced value disagrees with the
            // filtered one; any agreement (a glitch ending) restarts it.
            fcnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Quadrature step classification
    // Forward Gray sequence is 00 -> 01 -> 11 -> 10 -> 00.
    // -------------------------------------------------------------------------
    always_comb begin
        cur      = filt_q;
        step_fwd = ((prev_q == 2'b00) && (cur == 2'b01)) ||
                   ((prev_q == 2'b01) && (cur == 2'b11)) ||
                   ((prev_q == 2'b11) && (cur == 2'b10)) ||
                   ((prev_q == 2'b10) && (cur == 2'b00));
        step_rev = ((prev_q == 2'b01) && (cur == 2'b00)) ||
                   ((prev_q == 2'b11) && (cur == 2'b01)) ||
                   ((prev_q == 2'b10) && (cur == 2'b11)) ||
                   ((prev_q == 2'b00) && (cur == 2'b10));
        step_bad = ((cur ^ prev_q) == 2'b11);
        // A rise is seen in the same cycle the decoder sees the new state.
        a_rise    = cur[1] & ~prev_q[1];
        cnt_plus1 = cnt_q + PERIOD_WIDTH'(1);
    end

    // -------------------------------------------------------------------------
    // Decoder, error flag and period measurement FSM (next-state logic)
    // -------------------------------------------------------------------------
    always_comb begin
        prev_d  = cur;
        pos_d   = pos_q;
        dir_d   = dir_q;
        err_d   = err_q;
        meas_d  = meas_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        valid_d = 1'b0;
        stall_d = stall_q;

        if (step_fwd) begin
            pos_d = pos_q + POS_WIDTH'(1);
            dir_d = DIR_FWD;
        end else if (step_rev) begin
            pos_d = pos_q - POS_WIDTH'(1);
            dir_d = DIR_REV;
        end

        // Clear first so that a simultaneous new illegal step overrides it.
        if (clear_err) begin
            err_d = 1'b0;
        end
        if (step_bad) begin
            err_d = 1'b1;
        end

        case (meas_q)
            MEAS_IDLE: begin
                // First rise only starts the timebase; no period exists yet.
                cnt_d = '0;
                if (a_rise) begin
                    meas_d  = MEAS_ARMED;
                    stall_d = 1'b0;
                end
            end
            MEAS_ARMED: begin
                if (a_rise) begin
                    // cnt counts clocks since the previous rise minus one,
                    // so rises P clocks apart report exactly P.
                    per_d   = cnt_plus1;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_plus1 == STALL_LIM) begin
                    // A rise on this same clock takes the branch above.
                    meas_d  = MEAS_IDLE;
                    stall_d = 1'b1;
                    dir_d   = DIR_STOP;
                    per_d   = '1;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_plus1;
                end
            end
            default: begin
                meas_d = MEAS_IDLE;
                cnt_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q    <= 2'b00;
            sync_q    <= 2'b00;
            filt_q    <= 2'b00;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            prev_q    <= 2'b00;
            pos_q     <= '0;
            dir_q     <= DIR_STOP;
            err_q     <= 1'b0;
            meas_q    <= MEAS_IDLE;
            cnt_q     <= '0;
            per_q     <= '1;
            valid_q   <= 1'b0;
            stall_q   <= 1'b1;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            prev_q    <= prev_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            meas_q    <= meas_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
        end
    end

    assign position     = pos_q;
    assign direction    = dir_q;
    assign period_out   = per_q;
    assign period_valid = valid_q;
    assign stall        = stall_q;
    assign illegal_err  = err_q;

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_frontend
//
// Directed bench for quad_encoder_frontend with FILTER_LEN=4 and
// STALL_LIMIT=1000. Inputs change 1 ns after a falling clock edge and all
// sampling happens there too, well away from the rising edge. Period strobes
// are scored against an expected queue filled by the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_quad_encoder_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic        encoder_a;
    logic        encoder_b;
    logic        clear_err;
    logic [15:0] position;
    logic [1:0]  direction;
    logic [15:0] period_out;
    logic        period_valid;
    logic        stall;
    logic        illegal_err;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_head;
    bit          sb_on;

    quad_encoder_frontend #(
        .FILTER_LEN  (4),
        .PERIOD_WIDTH(16),
        .POS_WIDTH   (16),
        .STALL_LIMIT (1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .encoder_a   (encoder_a),
        .encoder_b   (encoder_b),
        .clear_err   (clear_err),
        .position    (position),
        .direction   (direction),
        .period_out  (period_out),
        .period_valid(period_valid),
        .stall       (stall),
        .illegal_err (illegal_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && period_valid && sb_on) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_head = exp_q.pop_front();
                check_eq("period_out", {16'h0, period_out}, {16'h0, exp_head});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic step(input logic a, input logic b, input int n);
        encoder_a = a;
        encoder_b = b;
        wait_clks(n);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_position"}, {16'h0, position}, 32'h0);
        check_eq({tag, "_direction"}, {30'h0, direction}, 32'h0);
        check_eq({tag, "_period"}, {16'h0, period_out}, 32'hFFFF);
        check_eq({tag, "_valid"}, {31'h0, period_valid}, 32'h0);
        check_eq({tag, "_stall"}, {31'h0, stall}, 32'h1);
        check_eq({tag, "_err"}, {31'h0, illegal_err}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        encoder_a = 1'b0;
        encoder_b = 1'b0;
        clear_err = 1'b0;
        sb_on     = 1'b1;
        wait_clks(3);
        check_reset_vals("rst");
        reset = 1'b0;
        wait_clks(2);

        // Forward rotation, 40 clocks per state.
        exp_q.push_back(16'd160);
        step(1'b0, 1'b1, 40);
        check_eq("fwd_stall_before_rise", {31'h0, stall}, 32'h1);
        step(1'b1, 1'b1, 40);
        check_eq("fwd_stall_after_rise", {31'h0, stall}, 32'h0);
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 40);
        step(1'b0, 1'b1, 40);
        step(1'b1, 1'b1, 40);
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 40);
        check_eq("fwd_position", {16'h0, position}, 32'd8);
        check_eq("fwd_direction", {30'h0, direction}, 32'h2);
        check_eq("fwd_strobes_seen", exp_q.size(), 32'd0);

        // Reverse rotation from zero.
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2);
        check_eq("rev_start_position", {16'h0, position}, 32'h0);
        exp_q.push_back(16'd160);
        step(1'b1, 1'b0, 40);
        check_eq("rev_first_position", {16'h0, position}, 32'hFFFF);
        check_eq("rev_direction", {30'h0, direction}, 32'h1);
        step(1'b1, 1'b1, 40);
        step(1'b0, 1'b1, 40);
        step(1'b0, 1'b0, 40);
        step(1'b1, 1'b0, 40);
        check_eq("rev_position", {16'h0, position}, 32'hFFFB);
        check_eq("rev_strobes_seen", exp_q.size(), 32'd0);

        // 3-clock glitch on A is rejected; 4-clock pulse passes
        // (10 -> 00 -> 10, net position unchanged, new A rise 67 clocks
        // after the previous one).
        encoder_a = 1'b0;
        wait_clks(3);
        encoder_a = 1'b1;
        wait_clks(20);
        check_eq("glitch_position", {16'h0, position}, 32'hFFFB);
        check_eq("glitch_direction", {30'h0, direction}, 32'h1);
        check_eq("glitch_err", {31'h0, illegal_err}, 32'h0);
        exp_q.push_back(16'd67);
        encoder_a = 1'b0;
        wait_clks(4);
        encoder_a = 1'b1;
        wait_clks(20);
        check_eq("pulse_strobes_seen", exp_q.size(), 32'd0);
        check_eq("pulse_position", {16'h0, position}, 32'hFFFB);
        check_eq("pulse_direction", {30'h0, direction}, 32'h1);
        check_eq("pulse_err", {31'h0, illegal_err}, 32'h0);

        // Illegal transitions and error clearing.
        step(1'b0, 1'b0, 40);
        check_eq("ill_pre_position", {16'h0, position}, 32'hFFFC);
        sb_on = 1'b0;
        step(1'b1, 1'b1, 10);
        check_eq("ill_err_set", {31'h0, illegal_err}, 32'h1);
        check_eq("ill_position", {16'h0, position}, 32'hFFFC);
        clear_err = 1'b1;
        wait_clks(1);
        clear_err = 1'b0;
        wait_clks(2);
        check_eq("ill_err_cleared", {31'h0, illegal_err}, 32'h0);
        step(1'b0, 1'b0, 6);
        check_eq("ill_err_before_set", {31'h0, illegal_err}, 32'h0);
        clear_err = 1'b1;
        wait_clks(1);
        clear_err = 1'b0;
        check_eq("ill_set_wins", {31'h0, illegal_err}, 32'h1);
        check_eq("ill_position2", {16'h0, position}, 32'hFFFC);
        check_eq("ill_direction", {30'h0, direction}, 32'h2);
        wait_clks(40);

        // Stall detection after a known 160-clock measurement.
        step(1'b0, 1'b1, 40);
        step(1'b1, 1'b1, 40);
        sb_on = 1'b1;
        exp_q.push_back(16'd160);
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 40);
        step(1'b0, 1'b1, 40);
        step(1'b1, 1'b1, 1006);
        check_eq("stall_not_yet", {31'h0, stall}, 32'h0);
        check_eq("stall_pre_strobes_seen", exp_q.size(), 32'd0);
        exp_q.push_back(16'hFFFF);
        wait_clks(1);
        check_eq("stall_set", {31'h0, stall}, 32'h1);
        check_eq("stall_direction", {30'h0, direction}, 32'h0);
        check_eq("stall_valid", {31'h0, period_valid}, 32'h1);
        check_eq("stall_period", {16'h0, period_out}, 32'hFFFF);
        check_eq("stall_strobes_seen", exp_q.size(), 32'd0);
        wait_clks(1);
        check_eq("stall_valid_one_cycle", {31'h0, period_valid}, 32'h0);

        // Recovery: first rise only re-arms, the next one measures.
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 40);
        step(1'b0, 1'b1, 40);
        check_eq("stall_held", {31'h0, stall}, 32'h1);
        step(1'b1, 1'b1, 40);
        check_eq("stall_cleared", {31'h0, stall}, 32'h0);
        exp_q.push_back(16'd160);
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 40);
        step(1'b0, 1'b1, 40);
        step(1'b1, 1'b1, 40);
        check_eq("recover_strobes_seen", exp_q.size(), 32'd0);
        check_eq("recover_position", {16'h0, position}, 32'h000A);
        check_eq("recover_direction", {30'h0, direction}, 32'h2);

        // Asynchronous reset between clock edges mid-rotation.
        step(1'b1, 1'b0, 20);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        wait_clks(3);
        reset = 1'b0;
        wait_clks(40);
        check_eq("post_rst_arm_strobes", exp_q.size(), 32'd0);
        check_eq("post_rst_stall", {31'h0, stall}, 32'h0);
        check_eq("post_rst_position", {16'h0, position}, 32'hFFFF);
        check_eq("post_rst_direction", {30'h0, direction}, 32'h1);
        step(1'b0, 1'b0, 40);
        exp_q.push_back(16'd80);
        step(1'b1, 1'b0, 40);
        check_eq("post_rst_strobes_seen", exp_q.size(), 32'd0);
        check_eq("post_rst_position2", {16'h0, position}, 32'hFFFF);

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
